// File: rtl/stream_arb_mux_if.sv
// rtl/stream_arb_mux_if.sv - N-channel input streams and single output stream of stream_arb_mux
interface stream_arb_mux_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_last;
  logic [SEL_W-1:0]   out_sel;
  logic               out_ready;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_sel
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_sel
  );
endinterface

// File: rtl/stream_arb_mux.sv
// rtl/stream_arb_mux.sv - N-to-1 stream mux with round-robin/fixed arbitration, packet lock, registered output
module stream_arb_mux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input logic             clk,
  input logic             rst_n,
  input logic             prio_mode,
  stream_arb_mux_if.slave bus
);
  typedef enum logic {S_OPEN, S_LOCKED} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] gnt;
  logic             gnt_valid;
  logic [SEL_W:0]   scan;
  logic [WIDTH-1:0] gnt_data;
  logic             gnt_last;
  logic             slot_free;
  logic             xfer;
  logic [N-1:0]     ready;

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             last_q;
  logic [SEL_W-1:0] sel_q;

  assign slot_free = !valid_q || bus.out_ready;
  assign xfer      = rst_n && slot_free && gnt_valid;

  // Loops run downward so the lowest index / nearest-to-ptr candidate is the last to win.
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    scan      = '0;
    if (state_q == S_LOCKED) begin
      gnt       = lock_ch_q;
      gnt_valid = bus.in_valid[lock_ch_q];
    end else if (prio_mode) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (bus.in_valid[i]) begin
          gnt       = SEL_W'(i);
          gnt_valid = 1'b1;
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        scan = {1'b0, ptr_q} + (SEL_W + 1)'(k);
        if (scan >= (SEL_W + 1)'(N)) scan = scan - (SEL_W + 1)'(N);
        if (bus.in_valid[scan[SEL_W-1:0]]) begin
          gnt       = scan[SEL_W-1:0];
          gnt_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    gnt_last = 1'b0;
    ready    = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == SEL_W'(i)) begin
        gnt_data = bus.in_data[i*WIDTH +: WIDTH];
        gnt_last = bus.in_last[i];
        ready[i] = xfer;
      end
    end
  end

  assign bus.in_ready = ready;

  // Pointer moves only at packet ends so a locked packet never perturbs fairness.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    ptr_d     = ptr_q;
    if (xfer) begin
      if (gnt_last) begin
        state_d = S_OPEN;
        ptr_d   = (gnt == SEL_W'(N - 1)) ? '0 : gnt + SEL_W'(1);
      end else begin
        state_d   = S_LOCKED;
        lock_ch_d = gnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_OPEN;
      lock_ch_q <= '0;
      ptr_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      sel_q     <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      ptr_q     <= ptr_d;
      if (xfer) begin
        data_q  <= gnt_data;
        last_q  <= gnt_last;
        sel_q   <= gnt;
        valid_q <= 1'b1;
      end else if (slot_free) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_stream_arb_mux.sv
// tb/tb_stream_arb_mux.sv - scoreboard bench for stream_arb_mux with directed vectors
module tb_stream_arb_mux;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SEL_W = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic prio_mode;

  always #5 clk = ~clk;

  stream_arb_mux_if #(.WIDTH(WIDTH), .N(N)) bus ();

  stream_arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prio_mode (prio_mode),
    .bus       (bus)
  );

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  beat_t exp_q[$];
  int    tests  = 0;
  int    fails  = 0;
  int    popped = 0;
  int    popped0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int s, input logic [WIDTH-1:0] d, input logic l);
    beat_t b;
    b.sel  = SEL_W'(s);
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [WIDTH-1:0] d, input logic l);
    bus.in_valid[ch]               = v;
    bus.in_data[ch*WIDTH +: WIDTH] = d;
    bus.in_last[ch]                = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    beat_t e;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got sel=%0d data=0x%0h, expected no beat", bus.out_sel, bus.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_sel", 32'(bus.out_sel), 32'(e.sel));
        chk("sb_data", 32'(bus.out_data), 32'(e.data));
        chk("sb_last", 32'(bus.out_last), 32'(e.last));
        popped++;
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    prio_mode     = 1'b0;
    bus.in_valid  = '0;
    bus.in_last   = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // reset and idle
    tick();
    bus.in_valid = 4'hF;
    bus.in_last  = 4'hF;
    sample();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_sel", 32'(bus.out_sel), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    tick();
    sample();
    chk("rst_in_ready2", 32'(bus.in_ready), 0);
    chk("rst_out_valid2", 32'(bus.out_valid), 0);
    rst_n        = 1'b1;
    bus.in_valid = '0;
    tick();
    sample();
    chk("idle_out_valid", 32'(bus.out_valid), 0);

    // round-robin fairness, single-beat packets
    tick();
    set_ch(0, 1'b1, 8'hAA, 1'b1);
    set_ch(1, 1'b1, 8'hBB, 1'b1);
    set_ch(2, 1'b1, 8'hCC, 1'b1);
    set_ch(3, 1'b1, 8'hDD, 1'b1);
    push(0, 8'hAA, 1); push(1, 8'hBB, 1); push(2, 8'hCC, 1); push(3, 8'hDD, 1);
    push(0, 8'hAA, 1); push(1, 8'hBB, 1); push(2, 8'hCC, 1); push(3, 8'hDD, 1);
    popped0 = popped;
    sample();
    chk("rr_first_ready", 32'(bus.in_ready), 32'h1);
    for (int i = 0; i < 8; i++) tick();
    bus.in_valid = '0;
    sample();
    chk("rr_throughput", popped - popped0, 8);
    tick();
    sample();
    chk("rr_drain_valid", 32'(bus.out_valid), 0);

    // fixed priority
    tick();
    prio_mode = 1'b1;
    set_ch(1, 1'b1, 8'h21, 1'b1);
    set_ch(3, 1'b1, 8'h43, 1'b1);
    push(1, 8'h21, 1); push(1, 8'h21, 1); push(1, 8'h21, 1);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("fp_ready_ch1", 32'(bus.in_ready), 32'h2);
      tick();
    end
    set_ch(1, 1'b0, 8'h00, 1'b0);
    push(3, 8'h43, 1);
    sample();
    chk("fp_ready_ch3", 32'(bus.in_ready), 32'h8);
    tick();
    set_ch(3, 1'b0, 8'h00, 1'b0);

    // one beat on channel 1 leaves ptr at 2
    prio_mode = 1'b0;
    set_ch(1, 1'b1, 8'h31, 1'b1);
    push(1, 8'h31, 1);
    tick();
    set_ch(1, 1'b0, 8'h00, 1'b0);

    // packet lock with prio_mode toggled mid-packet
    set_ch(0, 1'b1, 8'h50, 1'b1);
    set_ch(2, 1'b1, 8'h10, 1'b0);
    push(2, 8'h10, 0);
    sample();
    chk("lock_first_ready", 32'(bus.in_ready), 32'h4);
    tick();
    set_ch(2, 1'b1, 8'h11, 1'b0);
    prio_mode = 1'b1;
    push(2, 8'h11, 0);
    sample();
    chk("lock_hold_ready", 32'(bus.in_ready), 32'h4);
    tick();
    set_ch(2, 1'b1, 8'h12, 1'b1);
    push(2, 8'h12, 1);
    sample();
    chk("lock_last_ready", 32'(bus.in_ready), 32'h4);
    tick();
    set_ch(2, 1'b0, 8'h00, 1'b0);
    push(0, 8'h50, 1);
    sample();
    chk("lock_release_ready", 32'(bus.in_ready), 32'h1);
    tick();
    set_ch(0, 1'b0, 8'h00, 1'b0);

    // backpressure
    prio_mode = 1'b0;
    set_ch(1, 1'b1, 8'hBB, 1'b1);
    push(1, 8'hBB, 1);
    tick();
    bus.out_ready = 1'b0;
    set_ch(1, 1'b1, 8'hBC, 1'b1);
    push(1, 8'hBC, 1);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_out_data", 32'(bus.out_data), 32'hBB);
      chk("bp_out_sel", 32'(bus.out_sel), 1);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      tick();
    end
    bus.out_ready = 1'b1;
    sample();
    chk("bp_release_ready", 32'(bus.in_ready), 32'h2);
    tick();
    set_ch(1, 1'b0, 8'h00, 1'b0);
    sample();
    chk("bp_reload_data", 32'(bus.out_data), 32'hBC);
    tick();

    // reset in the middle of a packet on channel 3
    set_ch(3, 1'b1, 8'h60, 1'b0);
    push(3, 8'h60, 0);
    sample();
    chk("mid_first_ready", 32'(bus.in_ready), 32'h8);
    tick();
    rst_n = 1'b0;
    set_ch(3, 1'b1, 8'h61, 1'b0);
    sample();
    chk("mid_rst_ready", 32'(bus.in_ready), 0);
    tick();
    sample();
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    rst_n = 1'b1;
    set_ch(0, 1'b1, 8'h70, 1'b1);
    push(0, 8'h70, 1);
    #1;
    chk("mid_restart_ready", 32'(bus.in_ready), 32'h1);
    tick();
    set_ch(0, 1'b0, 8'h00, 1'b0);
    set_ch(3, 1'b1, 8'h61, 1'b1);
    push(3, 8'h61, 1);
    sample();
    chk("mid_ch3_ready", 32'(bus.in_ready), 32'h8);
    tick();
    set_ch(3, 1'b0, 8'h00, 1'b0);
    sample();
    tick();
    sample();
    chk("end_out_valid", 32'(bus.out_valid), 0);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
